// File: rtl/jtag_pkg.sv
// jtag_pkg: definitions shared by the JTAG scan engine and anything that
// talks to the TAP controller.
//   - tap_state_e : 4-bit TAP controller state encodings
//   - eng_state_e : scan engine FSM states
//   - IR_*        : 2-bit instruction opcodes
//   - INIT_LEN    : cycles of tms=1 used to force the TAP into Test-Logic-Reset
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_RESET      = 4'd0,
    TAP_RUN_IDLE   = 4'd1,
    TAP_SELECT_IR  = 4'd2,
    TAP_CAPTURE_IR = 4'd3,
    TAP_SHIFT_IR   = 4'd4,
    TAP_EXIT1_IR   = 4'd5,
    TAP_PAUSE_IR   = 4'd6,
    TAP_EXIT2_IR   = 4'd7,
    TAP_UPDATE_IR  = 4'd8,
    TAP_SELECT_DR  = 4'd9,
    TAP_CAPTURE_DR = 4'd10,
    TAP_SHIFT_DR   = 4'd11,
    TAP_EXIT1_DR   = 4'd12,
    TAP_PAUSE_DR   = 4'd13,
    TAP_EXIT2_DR   = 4'd14,
    TAP_UPDATE_DR  = 4'd15
  } tap_state_e;

  typedef enum logic [3:0] {
    ENG_INIT    = 4'd0,
    ENG_GO_IDLE = 4'd1,
    ENG_IDLE    = 4'd2,
    ENG_SEL_DR  = 4'd3,
    ENG_SEL_IR  = 4'd4,
    ENG_TO_CAP  = 4'd5,
    ENG_CAPTURE = 4'd6,
    ENG_SHIFT   = 4'd7,
    ENG_EXIT1   = 4'd8,
    ENG_UPDATE  = 4'd9,
    ENG_DONE    = 4'd10
  } eng_state_e;

  localparam logic [1:0] IR_EXTEST = 2'b00;
  localparam logic [1:0] IR_SAMPLE = 2'b01;
  localparam logic [1:0] IR_BYPASS = 2'b10;
  localparam logic [1:0] IR_IDCODE = 2'b11;

  localparam int INIT_LEN = 5;

endpackage

// File: rtl/jtag_scan_shifter.sv
// jtag_scan_shifter: datapath of one scan command.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : latch load_len/load_data and clear the capture register
//   shift        : the bit at tdi_bit has been issued; advance to the next one
//   sample       : store tdo into the next capture position
//   load_len     : number of bits of the command
//   load_data    : TDI word, consumed LSB first
//   tdo          : registered TDO from the TAP
//   tdi_bit      : next TDI bit to issue
//   last_bit     : the bit at tdi_bit is the final bit of the scan
//   capture      : captured TDO bits, LSB = first bit, unused bits 0
module jtag_scan_shifter #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic               sample,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               tdo,
  output logic               tdi_bit,
  output logic               last_bit,
  output logic [MAX_LEN-1:0] capture
);

  logic [MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;   // bits not yet issued
  logic [LEN_W-1:0]   idx_q, idx_d;   // next capture position
  logic [MAX_LEN-1:0] cap_q, cap_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    cap_d  = cap_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_len;
      idx_d  = '0;
      cap_d  = '0;
    end else begin
      if (shift) begin
        data_d = data_q >> 1;
        cnt_d  = cnt_q - LEN_W'(1);
      end
      if (sample) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (idx_q == LEN_W'(i)) cap_d[i] = tdo;
        end
        idx_d = idx_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      cap_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      cap_q  <= cap_d;
    end
  end

  assign tdi_bit  = data_q[0];
  assign last_bit = (cnt_q == LEN_W'(1));
  assign capture  = cap_q;

endmodule

// File: rtl/jtag_scan_engine.sv
// jtag_scan_engine: command-driven JTAG master placed in front of a TAP
// controller sharing the same clock. Walks the TAP through one IR or DR
// scan per command and returns the captured TDO bits.
//   tclk, trst_n : clock, asynchronous active-low reset
//   cmd_*        : command channel (valid/ready), is_ir, len, data
//   rsp_*        : one-cycle response pulse with captured data and error flag
//   tms, tdi     : to the TAP;  tdo : registered TDO from the TAP
//   dbg_state    : current engine FSM state (eng_state_e encoding)
// Every output comes straight from a flop: each output register is loaded
// with the value belonging to the state being entered (state_d).
//
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both 1; the command fields are latched on that edge only.
// cmd_ready is 1 in IDLE and DONE. rsp_valid is a single-cycle pulse with
// no back-pressure; rsp_err and rsp_data are meaningful while it is 1.
module jtag_scan_engine
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tclk,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [3:0]         dbg_state
);

  eng_state_e         state_q, state_d;
  logic [2:0]         init_cnt_q, init_cnt_d;
  logic               is_ir_q, is_ir_d;
  logic               was_shift_q;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic               accept;
  logic               len_ok;
  logic               sh_tdi_bit;
  logic               sh_last_bit;
  logic [MAX_LEN-1:0] sh_capture;

  assign accept = cmd_valid && ready_q;
  assign len_ok = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    is_ir_d    = is_ir_q;
    unique case (state_q)
      ENG_INIT: begin
        init_cnt_d = init_cnt_q + 3'd1;
        if (init_cnt_q == 3'(INIT_LEN - 1)) state_d = ENG_GO_IDLE;
      end
      ENG_GO_IDLE: state_d = ENG_IDLE;
      ENG_IDLE, ENG_DONE: begin
        if (accept) begin
          is_ir_d = cmd_is_ir;
          // An illegal length never touches the TAP: straight to DONE.
          state_d = len_ok ? ENG_SEL_DR : ENG_DONE;
        end else begin
          state_d = ENG_IDLE;
        end
      end
      ENG_SEL_DR:  state_d = is_ir_q ? ENG_SEL_IR : ENG_TO_CAP;
      ENG_SEL_IR:  state_d = ENG_TO_CAP;
      ENG_TO_CAP:  state_d = ENG_CAPTURE;
      ENG_CAPTURE: state_d = ENG_SHIFT;
      // tms=1 during SHIFT marks the bit being driven as the final one.
      ENG_SHIFT:   if (tms_q) state_d = ENG_EXIT1;
      ENG_EXIT1:   state_d = ENG_UPDATE;
      ENG_UPDATE:  state_d = ENG_DONE;
      default:     state_d = ENG_INIT;
    endcase
  end

  always_comb begin
    tms_d = 1'b0;
    unique case (state_d)
      ENG_INIT, ENG_SEL_DR, ENG_SEL_IR, ENG_EXIT1: tms_d = 1'b1;
      ENG_SHIFT: tms_d = sh_last_bit;
      default:   tms_d = 1'b0;
    endcase
    tdi_d       = (state_d == ENG_SHIFT) ? sh_tdi_bit : 1'b0;
    ready_d     = (state_d == ENG_IDLE) || (state_d == ENG_DONE);
    rsp_valid_d = (state_d == ENG_DONE);
    // DONE entered via accept can only be the illegal-length case.
    rsp_err_d   = accept && !len_ok;
    rsp_data_d  = rsp_data_q;
    if (state_d == ENG_DONE) rsp_data_d = accept ? '0 : sh_capture;
  end

  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= ENG_INIT;
      init_cnt_q  <= '0;
      is_ir_q     <= 1'b0;
      was_shift_q <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      is_ir_q     <= is_ir_d;
      was_shift_q <= (state_q == ENG_SHIFT);
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // The TAP registers tdo, so the bit for shift cycle k is sampled one
  // cycle later: every edge that follows a SHIFT cycle (the last in EXIT1).
  jtag_scan_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk       (tclk),
    .rst_n     (trst_n),
    .load      (accept && len_ok),
    .shift     (state_d == ENG_SHIFT),
    .sample    (was_shift_q),
    .load_len  (cmd_len),
    .load_data (cmd_data),
    .tdo       (tdo),
    .tdi_bit   (sh_tdi_bit),
    .last_bit  (sh_last_bit),
    .capture   (sh_capture)
  );

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign dbg_state = state_q;

endmodule

// File: doc/jtag_scan_engine.md
# jtag_scan_engine

- Command-driven JTAG master that sits directly upstream of the TAP controller.
- Accepts one IR-scan or DR-scan command at a time and walks the TAP state machine by driving `tms`/`tdi`.
- Samples the TAP's registered `tdo` and returns the captured bits as a single-cycle response.
- Gives the automated test sequencer a transaction-level view of the scan chain.

## Interface
- `MAX_LEN`, default 8: maximum scan length in bits; width of `cmd_data` and `rsp_data`.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of `cmd_len`.
- `tclk`  in  1: the single clock; the same clock runs the TAP controller.
- `trst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the engine is idle and will accept a command.
- `cmd_is_ir`  in  1: 1 = IR scan, 0 = DR scan.
- `cmd_len`  in  LEN_W: number of bits to shift; legal range 1..MAX_LEN.
- `cmd_data`  in  MAX_LEN: TDI bits, shifted LSB first.
- `rsp_valid`  out  1: one-cycle pulse when a command completes.
- `rsp_data`  out  MAX_LEN: captured TDO bits, LSB = first bit; bits at index ≥ len are 0.
- `rsp_err`  out  1: qualifies `rsp_valid`; set when the command length was illegal.
- `tms`  out  1: to the TAP.
- `tdi`  out  1: to the TAP.
- `tdo`  in  1: from the TAP; registered in the TAP, so valid one cycle after its shift cycle.

## Operation
- **Output registration:** all outputs are registered. "Cycle X drives v" means v is stable for all of cycle X and is sampled by the TAP at the edge that ends cycle X.
- **Reset values:** `tms`=1, `tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
- **Engine states and `tms` per cycle:**
  - INIT: 5 cycles, tms=1.
  - GO_IDLE: 1 cycle, tms=0.
  - IDLE: tms=0, `cmd_ready`=1.
  - SEL_DR: TAP in Run-Test/Idle, tms=1.
  - SEL_IR: TAP in Select-DR, tms=1; IR scans only.
  - TO_CAP: TAP in Select-DR or Select-IR, tms=0.
  - CAPTURE: TAP in Capture, tms=0.
  - SHIFT: `cmd_len` cycles. Bit k drives `tdi=data[k]`; tms=0, except tms=1 on bit len-1.
  - EXIT1: tms=1.
  - UPDATE: tms=0.
  - DONE: `rsp_valid`=1, `cmd_ready`=1.
- **Accept:** a command is accepted on an edge with `cmd_valid && cmd_ready`. `cmd_is_ir`, `cmd_len` and `cmd_data` are latched at that edge and ignored afterwards.
- **Scan path from accept:**
  - DR: IDLE → SEL_DR → TO_CAP → CAPTURE → SHIFT → EXIT1 → UPDATE → DONE.
  - IR: IDLE → SEL_DR → SEL_IR → TO_CAP → CAPTURE → SHIFT → EXIT1 → UPDATE → DONE.
- **TDO capture:** `tdo` bit k is sampled at the edge ending the cycle after shift bit k. The last sample is taken at the edge ending EXIT1. `rsp_data[k]` holds that sample.
- **`tdi` outside SHIFT:** 0.
- **DONE behaviour:**
  - `cmd_ready`=1 in DONE, so a command may be accepted in the DONE cycle.
  - If one is accepted, the next state is SEL_DR directly, with no IDLE cycle.
  - Otherwise the next state is IDLE.
  - `rsp_data` holds its value until the next DONE.
- **Illegal length** (`cmd_len`=0 or `cmd_len` > MAX_LEN):
  - No TAP activity; tms stays 0.
  - DONE follows in the next cycle with `rsp_err`=1 and `rsp_data`=0.
- **Reset mid-operation:** asserting `trst_n` at any point aborts the command with no response, forces the reset values, and restarts from INIT.

## Timing
- **Accept cycle:** the accept edge ends cycle c; cycle c itself still drives tms=0.
- **Response latency:** `rsp_valid` in cycle c+6+N for a DR scan, c+7+N for an IR scan.
- **Back-to-back throughput:** one command per N+6 (DR) or N+7 (IR) cycles.
- **After reset release:** `cmd_ready` first rises in the 7th cycle (5 INIT + 1 GO_IDLE).
- **Illegal length:** `rsp_valid` in cycle c+1.

## Structure
- **Shared package `jtag_pkg`:**
  - 4-bit TAP state encodings (RESET=0 … UPDATE_DR=15, as the TAP controller uses).
  - Engine state enum.
  - IR opcode constants: EXTEST=00, SAMPLE=01, BYPASS=10, IDCODE=11.
  - INIT length constant (5).
- **Sub-module `jtag_scan_shifter`:**
  - Holds the latched TDI word, the bit counter and the TDO capture register.
  - Inputs: load, shift, sample strobes.
  - Outputs: the current TDI bit and the last-bit flag.
- **Top level:** the engine FSM and handshake.

## Test plan
Bench: engine wired to the TAP controller with the shared `tclk`/`trst_n` and DATA_REG=5.
1. **Reset release:** `tms` reads 1,1,1,1,1,0, then `cmd_ready`=1 with the TAP in Run-Test/Idle.
2. **IR scan** len=2, data=2'b10 (BYPASS): `rsp_valid` at c+9, `rsp_data`=2'b01, TAP shadow IR = BYPASS.
3. **DR scan after step 2** len=4, data=4'b1011: `rsp_valid` at c+10, `rsp_data`=4'b0110 (bypass delays by one bit, first bit 0).
4. **Back-to-back:** two DR scans with `cmd_valid` held high. The second is accepted in the first's DONE cycle, and its SEL_DR `tms`=1 appears in the next cycle.
5. **Illegal length:** `cmd_len`=0 gives `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0 one cycle after accept, with `tms` held at 0 throughout.
6. **Reset mid-scan:** `trst_n` pulsed low during SHIFT gives no `rsp_valid`, outputs at reset values, and a full INIT sequence again before `cmd_ready`.
